// File: rtl/ofdm_symbol_sequencer.sv
// Frame sequencer behind the Minn preamble detector: skips the preamble symbol,
// then cuts CP-stripped NFFT-sample windows tagged with start/last/index sidebands.
module ofdm_symbol_sequencer #(
    parameter int INPUT_WIDTH = 12,
    parameter int NFFT        = 2048,
    parameter int CP_LEN      = 512,
    parameter int CP_BACKOFF  = 16,
    parameter int SYM_WIDTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic        [SYM_WIDTH-1:0]   cfg_num_symbols,
    input  logic                          in_valid,
    input  logic signed [INPUT_WIDTH-1:0] in_ch0_i,
    input  logic signed [INPUT_WIDTH-1:0] in_ch0_q,
    input  logic signed [INPUT_WIDTH-1:0] in_ch1_i,
    input  logic signed [INPUT_WIDTH-1:0] in_ch1_q,
    input  logic                          in_frame_start,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [INPUT_WIDTH-1:0] out_ch0_i,
    output logic signed [INPUT_WIDTH-1:0] out_ch0_q,
    output logic signed [INPUT_WIDTH-1:0] out_ch1_i,
    output logic signed [INPUT_WIDTH-1:0] out_ch1_q,
    output logic                          out_sym_start,
    output logic                          out_sym_last,
    output logic        [SYM_WIDTH-1:0]   out_sym_index,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          overrun,
    output logic        [15:0]            frame_count
);

    localparam int CNT_MAX  = (NFFT > CP_LEN) ? NFFT : CP_LEN;
    localparam int CW       = $clog2(CNT_MAX + 1);
    localparam int SKIP_LEN = CP_LEN - CP_BACKOFF;

    localparam logic [CW-1:0] NFFT_LAST = CW'(NFFT - 1);
    localparam logic [CW-1:0] SKIP_LAST = CW'(SKIP_LEN - 1);
    localparam logic [CW-1:0] TAIL_LAST = CW'(CP_BACKOFF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEARCH,
        S_PREAMBLE,
        S_CP_SKIP,
        S_CAPTURE,
        S_TAIL
    } state_t;

    // With the whole CP consumed by the backoff, the window opens right after the previous symbol.
    localparam state_t SYM_ENTRY = (SKIP_LEN == 0) ? S_CAPTURE : S_CP_SKIP;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [SYM_WIDTH-1:0] sym;
    logic [SYM_WIDTH-1:0] nsym;
    logic                 last_sym;

    assign last_sym = (SYM_WIDTH'(sym + 1'b1) == nsym);
    assign busy     = (state != S_IDLE) && (state != S_SEARCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            sym           <= '0;
            nsym          <= '0;
            out_valid     <= 1'b0;
            out_ch0_i     <= '0;
            out_ch0_q     <= '0;
            out_ch1_i     <= '0;
            out_ch1_q     <= '0;
            out_sym_start <= 1'b0;
            out_sym_last  <= 1'b0;
            out_sym_index <= '0;
            frame_done    <= 1'b0;
            overrun       <= 1'b0;
            frame_count   <= '0;
        end else begin
            frame_done <= 1'b0;
            if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (!enable) begin
                state     <= S_IDLE;
                out_valid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state <= S_SEARCH;
                        cnt   <= '0;
                        sym   <= '0;
                    end
                    S_SEARCH: begin
                        // The flagged sample is itself preamble sample 0.
                        if (in_valid && in_frame_start) begin
                            state <= S_PREAMBLE;
                            cnt   <= CW'(1);
                            sym   <= '0;
                            nsym  <= cfg_num_symbols;
                        end
                    end
                    S_PREAMBLE: begin
                        if (in_valid) begin
                            if (cnt == NFFT_LAST) begin
                                cnt <= '0;
                                if (nsym == '0) begin
                                    state       <= S_SEARCH;
                                    frame_done  <= 1'b1;
                                    frame_count <= frame_count + 1'b1;
                                end else begin
                                    state <= SYM_ENTRY;
                                end
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    S_CP_SKIP: begin
                        if (in_valid) begin
                            if (cnt == SKIP_LAST) begin
                                cnt   <= '0;
                                state <= S_CAPTURE;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    S_CAPTURE: begin
                        if (in_valid) begin
                            // A stalled output register cannot absorb another sample: abort the frame.
                            if (out_valid && !out_ready) begin
                                overrun   <= 1'b1;
                                out_valid <= 1'b0;
                                state     <= S_SEARCH;
                                cnt       <= '0;
                                sym       <= '0;
                            end else begin
                                out_valid     <= 1'b1;
                                out_ch0_i     <= in_ch0_i;
                                out_ch0_q     <= in_ch0_q;
                                out_ch1_i     <= in_ch1_i;
                                out_ch1_q     <= in_ch1_q;
                                out_sym_start <= (cnt == '0);
                                out_sym_last  <= (cnt == NFFT_LAST);
                                out_sym_index <= sym;
                                if (cnt == NFFT_LAST) begin
                                    cnt <= '0;
                                    if (CP_BACKOFF == 0) begin
                                        if (last_sym) begin
                                            state       <= S_SEARCH;
                                            sym         <= '0;
                                            frame_done  <= 1'b1;
                                            frame_count <= frame_count + 1'b1;
                                        end else begin
                                            state <= SYM_ENTRY;
                                            sym   <= sym + 1'b1;
                                        end
                                    end else begin
                                        state <= S_TAIL;
                                    end
                                end else begin
                                    cnt <= cnt + 1'b1;
                                end
                            end
                        end
                    end
                    S_TAIL: begin
                        if (in_valid) begin
                            if (cnt == TAIL_LAST) begin
                                cnt <= '0;
                                if (last_sym) begin
                                    state       <= S_SEARCH;
                                    sym         <= '0;
                                    frame_done  <= 1'b1;
                                    frame_count <= frame_count + 1'b1;
                                end else begin
                                    state <= SYM_ENTRY;
                                    sym   <= sym + 1'b1;
                                end
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ofdm_symbol_sequencer.sv
// Directed bench for ofdm_symbol_sequencer with a small NFFT=16/CP=4/backoff=1 geometry;
// expected windows are queued as samples are driven and popped when the output appears.
module tb_ofdm_symbol_sequencer;

    localparam int W     = 12;
    localparam int SW    = 8;
    localparam int NF    = 16;
    localparam int CP    = 4;
    localparam int BO    = 1;
    localparam int PER   = NF + CP;
    localparam int SKIP  = CP - BO;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [SW-1:0] cfg_num_symbols;
    logic          in_valid;
    logic [W-1:0]  in_ch0_i, in_ch0_q, in_ch1_i, in_ch1_q;
    logic          in_frame_start;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_ch0_i, out_ch0_q, out_ch1_i, out_ch1_q;
    logic          out_sym_start, out_sym_last;
    logic [SW-1:0] out_sym_index;
    logic          busy, frame_done, overrun;
    logic [15:0]   frame_count;

    ofdm_symbol_sequencer #(
        .INPUT_WIDTH(W), .NFFT(NF), .CP_LEN(CP), .CP_BACKOFF(BO), .SYM_WIDTH(SW)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .cfg_num_symbols(cfg_num_symbols),
        .in_valid(in_valid), .in_ch0_i(in_ch0_i), .in_ch0_q(in_ch0_q),
        .in_ch1_i(in_ch1_i), .in_ch1_q(in_ch1_q), .in_frame_start(in_frame_start),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ch0_i(out_ch0_i), .out_ch0_q(out_ch0_q), .out_ch1_i(out_ch1_i), .out_ch1_q(out_ch1_q),
        .out_sym_start(out_sym_start), .out_sym_last(out_sym_last), .out_sym_index(out_sym_index),
        .busy(busy), .frame_done(frame_done), .overrun(overrun), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] i0, q0, i1, q1;
    } smp_t;

    typedef struct {
        smp_t          s;
        bit            st;
        bit            la;
        logic [SW-1:0] ix;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cur_idx = 0;
    int          abort_at = -1;
    bit          m_idle, m_active, m_overrun;
    int          m_f, m_n;
    logic [15:0] m_count;

    function automatic smp_t mk(input int idx);
        smp_t s;
        logic [W-1:0] v;
        v    = W'(idx);
        s.i0 = v;
        s.q0 = -v;
        s.i1 = v ^ 12'h5A5;
        s.q1 = ~v;
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s at idx %0d: observed=%0h expected=%0h", tag, cur_idx, obs, exp);
        end
    endtask

    task automatic check_outputs(input bit exp_done);
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("out_valid", {31'd0, out_valid}, 32'd1);
            chk("ch0_i", {20'd0, out_ch0_i}, {20'd0, e.s.i0});
            chk("ch0_q", {20'd0, out_ch0_q}, {20'd0, e.s.q0});
            chk("ch1_i", {20'd0, out_ch1_i}, {20'd0, e.s.i1});
            chk("ch1_q", {20'd0, out_ch1_q}, {20'd0, e.s.q1});
            chk("sym_start", {31'd0, out_sym_start}, {31'd0, e.st});
            chk("sym_last", {31'd0, out_sym_last}, {31'd0, e.la});
            chk("sym_index", {24'd0, out_sym_index}, {24'd0, e.ix});
        end else begin
            chk("out_valid", {31'd0, out_valid}, 32'd0);
        end
        chk("frame_done", {31'd0, frame_done}, {31'd0, exp_done});
        chk("busy", {31'd0, busy}, {31'd0, m_active});
        chk("overrun", {31'd0, overrun}, {31'd0, m_overrun});
        chk("frame_count", {16'd0, frame_count}, {16'd0, m_count});
    endtask

    // One clock: drive a sample, predict its effect from the frame geometry, then check.
    task automatic step(input int idx, input bit v, input bit fs, input bit en, input bit rdy);
        smp_t s;
        exp_t e;
        bit   exp_done;
        int   d, r, sy, last_d;
        @(negedge clk);
        cur_idx        = idx;
        s              = mk(v ? idx : idx + 1000);
        rst            = 1'b0;
        in_valid       = v;
        in_frame_start = fs;
        enable         = en;
        out_ready      = rdy;
        in_ch0_i       = s.i0;
        in_ch0_q       = s.q0;
        in_ch1_i       = s.i1;
        in_ch1_q       = s.q1;
        exp_done       = 1'b0;
        if (!en) begin
            m_idle   = 1'b1;
            m_active = 1'b0;
        end else if (m_idle) begin
            m_idle = 1'b0;
        end else if (v && !m_active) begin
            if (fs) begin
                m_active = 1'b1;
                m_f      = idx;
                m_n      = int'(cfg_num_symbols);
            end
        end else if (v) begin
            d = idx - m_f;
            if (idx == abort_at) begin
                m_active  = 1'b0;
                m_overrun = 1'b1;
            end else begin
                if (d >= NF) begin
                    r  = (d - NF) % PER;
                    sy = (d - NF) / PER;
                    if (sy < m_n && r >= SKIP && r < SKIP + NF) begin
                        e.s  = mk(idx);
                        e.st = (r == SKIP);
                        e.la = (r == SKIP + NF - 1);
                        e.ix = SW'(sy);
                        sb.push_back(e);
                    end
                end
                last_d = (m_n == 0) ? NF - 1 : NF + PER * m_n - 1;
                if (d == last_d) begin
                    m_active = 1'b0;
                    exp_done = 1'b1;
                    m_count  = m_count + 16'd1;
                end
            end
        end
        @(posedge clk);
        #1;
        check_outputs(exp_done);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        cur_idx        = -1;
        rst            = 1'b1;
        enable         = 1'b1;
        in_valid       = 1'b1;
        in_frame_start = 1'b1;
        out_ready      = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sym_start", {31'd0, out_sym_start}, 32'd0);
        chk("rst_sym_last", {31'd0, out_sym_last}, 32'd0);
        chk("rst_sym_index", {24'd0, out_sym_index}, 32'd0);
        chk("rst_ch0_i", {20'd0, out_ch0_i}, 32'd0);
        chk("rst_ch0_q", {20'd0, out_ch0_q}, 32'd0);
        chk("rst_ch1_i", {20'd0, out_ch1_i}, 32'd0);
        chk("rst_ch1_q", {20'd0, out_ch1_q}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_frame_count", {16'd0, frame_count}, 32'd0);
        sb.delete();
        m_idle    = 1'b1;
        m_active  = 1'b0;
        m_overrun = 1'b0;
        m_count   = 16'd0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst             = 1'b1;
        enable          = 1'b0;
        cfg_num_symbols = 8'd2;
        in_valid        = 1'b0;
        in_frame_start  = 1'b0;
        out_ready       = 1'b1;
        {in_ch0_i, in_ch0_q, in_ch1_i, in_ch1_q} = '0;
        m_f = 0;
        m_n = 0;
        repeat (2) @(posedge clk);
        reset_pulse();

        // Basic two-symbol frame; cfg changes after the start must not matter.
        for (int i = 0; i <= 160; i++) begin
            cfg_num_symbols = (i > 100) ? 8'd5 : 8'd2;
            step(i, 1'b1, i == 100, 1'b1, 1'b1);
        end

        // Same frame with idle cycles between samples (garbage data and frame_start in gaps).
        cfg_num_symbols = 8'd2;
        for (int i = 0; i <= 160; i++) begin
            step(i, 1'b1, i == 100, 1'b1, 1'b1);
            step(i, 1'b0, 1'b1, 1'b1, 1'b1);
        end

        // Zero data symbols: preamble only.
        cfg_num_symbols = 8'd0;
        for (int i = 0; i <= 130; i++) step(i, 1'b1, i == 100, 1'b1, 1'b1);

        // Re-trigger mid-frame ignored, back-to-back frame accepted.
        cfg_num_symbols = 8'd2;
        for (int i = 0; i <= 215; i++) step(i, 1'b1, i == 100 || i == 125 || i == 156, 1'b1, 1'b1);

        // Overrun: sink stalls after sample 120, then a clean frame follows.
        abort_at = 121;
        for (int i = 0; i <= 160; i++) step(i, 1'b1, i == 100, 1'b1, i <= 120);
        abort_at = -1;
        for (int i = 0; i <= 160; i++) step(i, 1'b1, i == 100, 1'b1, 1'b1);

        // Enable drop mid-capture, then reset, then a normal frame.
        for (int i = 0; i <= 130; i++) step(i, 1'b1, i == 100, !(i >= 125 && i <= 127), 1'b1);
        reset_pulse();
        for (int i = 0; i <= 160; i++) step(i, 1'b1, i == 100, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ofdm_symbol_sequencer.md
# ofdm_symbol_sequencer

Frame sequencer placed directly after the Minn preamble detector. It consumes the detector's delayed sample stream and `frame_start` flag, steps over the preamble symbol, and then cuts a configurable number of CP-stripped NFFT-sample windows for the FFT. Each window is tagged with start/last/index sidebands. Loss of an output sample aborts the frame and sets a sticky error.

## Interface
- INPUT_WIDTH, 12, sample component width (signed)
- NFFT, 2048, FFT window / useful symbol length in samples
- CP_LEN, 512, cyclic prefix length in samples
- CP_BACKOFF, 16, window advance into CP (0..CP_LEN); tail samples discarded per symbol
- SYM_WIDTH, 8, width of symbol count/index
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- enable  in  1  sequencer run; low forces IDLE
- cfg_num_symbols  in  SYM_WIDTH  data symbols per frame, latched on accepted frame_start
- in_valid  in  1  input sample strobe
- in_ch0_i, in_ch0_q, in_ch1_i, in_ch1_q  in  INPUT_WIDTH each  input sample
- in_frame_start  in  1  qualified by in_valid; marks first useful (post-CP) preamble sample
- out_valid  out  1  captured sample valid
- out_ready  in  1  FFT accepts sample
- out_ch0_i, out_ch0_q, out_ch1_i, out_ch1_q  out  INPUT_WIDTH each  captured sample
- out_sym_start  out  1  first sample of a window
- out_sym_last  out  1  last (NFFT-th) sample of a window
- out_sym_index  out  SYM_WIDTH  data symbol number, 0-based
- busy  out  1  state not IDLE/SEARCH
- frame_done  out  1  one-cycle pulse after last tail sample of a complete frame
- overrun  out  1  sticky; cleared only by rst
- frame_count  out  16  completed frames, wraps

## Operation
- States: IDLE, SEARCH, PREAMBLE, CP_SKIP, CAPTURE, TAIL.
- Sample counter `cnt` is CLOG2(max(NFFT,CP_LEN)+1) bits wide. Symbol counter `sym` is SYM_WIDTH bits wide. Both advance only on in_valid.
- IDLE: enable=1 -> SEARCH.
- SEARCH: in_valid && in_frame_start -> PREAMBLE with cnt=1 (the flagged sample is preamble sample 0). cfg_num_symbols is latched as nsym, sym=0.
- PREAMBLE: consumes NFFT samples in total. After the last one: nsym=0 -> SEARCH with frame_done pulse and frame_count+1; else -> CP_SKIP.
- CP_SKIP: discards CP_LEN-CP_BACKOFF samples. If that count is 0, go straight to CAPTURE.
- CAPTURE: forwards NFFT samples. The first sample carries out_sym_start; sample NFFT-1 carries out_sym_last. out_sym_index=sym. Then -> TAIL, or if CP_BACKOFF=0 advance the symbol immediately.
- TAIL: discards CP_BACKOFF samples, then advances the symbol.
- Symbol advance: sym+1. If sym+1==nsym -> SEARCH with frame_done and frame_count+1; else -> CP_SKIP.
- in_frame_start outside SEARCH is ignored; there is no re-trigger mid-frame.
- Output register:
  - A capture sample loads the output register when !out_valid || out_ready.
  - If out_valid && !out_ready while a new capture sample arrives, overrun is set, out_valid is cleared, and the state goes to SEARCH with no frame_done.
  - out_valid clears when out_ready is high and no new capture sample arrives.
- enable=0 in any state -> IDLE next cycle and out_valid cleared. Counters are reset on the next entry into SEARCH.

## Timing
- Reset values: state IDLE; out_valid, out_sym_start, out_sym_last, frame_done, busy, overrun = 0; out samples and out_sym_index = 0; frame_count=0.
- Latency: capture input sample at cycle t -> out_valid at t+1.
- Sideband outputs are registered alongside the data. frame_done is registered the cycle after the qualifying in_valid.
- Transition to SEARCH happens on the clock edge of the final sample. A frame_start on the very next in_valid is accepted.
- Per-symbol period is exactly CP_LEN+NFFT input samples, independent of in_valid gaps.
- rst mid-frame: all state returns to reset values on the next edge.

## Test plan
- Sequence: NFFT=16, CP_LEN=4, CP_BACKOFF=1, nsym=2, out_ready=1. Sample value = index; frame_start at index 100.
  -> Captures 119–134 (sym 0) and 139–154 (sym 1).
  -> start on 119/139, last on 134/154.
  -> frame_done one cycle after 155; frame_count=1; state SEARCH at 156.
- in_valid gaps: same stimulus with in_valid toggling 1/0 -> identical captured values and flags; out_valid only follows valid inputs.
- Zero symbols: cfg_num_symbols=0 -> no out_valid; frame_done after sample 115.
- Re-trigger ignored / immediate restart:
  -> frame_start re-asserted at index 125 is ignored.
  -> New frame_start at 156 is accepted, with first capture at 175.
- Overrun: hold out_ready=0 from the sample after index 120.
  -> overrun=1 on sample 121; no further out_valid; no frame_done.
  -> A later frame still captures normally with overrun still 1.
- Enable drop and reset: enable=0 at index 125 -> IDLE; out_valid low next cycle. Then rst -> all outputs 0, frame_count=0.
